// File: rtl/aether_mem_pkg.sv
// Shared command encodings and client state type for the Aether memory-port client.
package aether_mem_pkg;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_WRITE = 2'b01;
  localparam logic [1:0] MEM_READ  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE
  } client_state_e;

endpackage

// File: rtl/aether_engine_mem_client_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and synchronous flush.
module sync_fifo #(
  parameter int Width = 16,
  parameter int Depth = 64
) (
  input  logic                     clk_i,
  input  logic                     flush_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr;
  logic [PtrW-1:0]  rptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == CntW'(Depth));
  assign count_o = count;
  assign rdata_o = mem[rptr];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (!flush_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PtrW'(1);
      if (do_pop)  rptr <= rptr + PtrW'(1);
      count <= count + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata_i;
  end

endmodule

// File: rtl/aether_engine_mem_client.sv
// Initiator-side block-transfer controller for the Aether generic memory port.
module aether_engine_mem_client #(
  parameter int FifoDepth = 64,
  parameter int AddrWidth = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_write_i,
  input  logic [AddrWidth-1:0]         req_start_addr_i,
  input  logic [$clog2(FifoDepth):0]   req_length_i,
  input  logic [15:0]                  wr_data_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  output logic [15:0]                  rd_data_o,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic                         done_o,
  output logic                         err_o,
  output logic [1:0]                   mem_command_o,
  output logic [AddrWidth-1:0]         mem_start_addr_o,
  output logic [AddrWidth-1:0]         mem_end_addr_o,
  output logic [15:0]                  mem_data_write_o,
  input  logic [15:0]                  mem_data_read_i,
  input  logic                         mem_read_valid_i,
  input  logic                         mem_write_ready_i,
  input  logic                         mem_task_finished_i,
  input  logic                         mem_running_i
);

  import aether_mem_pkg::*;

  localparam int              LenW     = $clog2(FifoDepth) + 1;
  localparam logic [LenW-1:0] DepthLen = LenW'(FifoDepth);

  client_state_e        state;
  logic                 is_write;
  logic                 armed;
  logic                 err_q;
  logic                 done_q;
  logic                 req_ready_q;
  logic [1:0]           command_q;
  logic [AddrWidth-1:0] start_q;
  logic [AddrWidth-1:0] end_q;
  logic [LenW-1:0]      len_q;
  logic [LenW-1:0]      pop_cnt;

  logic [15:0]          wf_rdata;
  logic [LenW-1:0]      wf_count;
  logic                 wf_full;
  logic                 wf_empty;
  logic                 wf_push;
  logic                 wf_pop;

  logic [LenW-1:0]      rf_count;
  logic [LenW-1:0]      rf_free;
  logic                 rf_full;
  logic                 rf_empty;
  logic                 rf_pop;

  logic                 accept;
  logic                 len_bad;
  logic                 write_active;
  logic                 wr_strobe_err;
  logic                 rd_overflow;
  logic                 fill_ok;

  sync_fifo #(.Width(16), .Depth(FifoDepth)) u_wr_fifo (
    .clk_i   (clk_i),
    .flush_ni(rst_ni),
    .push_i  (wf_push),
    .wdata_i (wr_data_i),
    .pop_i   (wf_pop),
    .rdata_o (wf_rdata),
    .count_o (wf_count),
    .full_o  (wf_full),
    .empty_o (wf_empty)
  );

  sync_fifo #(.Width(16), .Depth(FifoDepth)) u_rd_fifo (
    .clk_i   (clk_i),
    .flush_ni(rst_ni),
    .push_i  (mem_read_valid_i),
    .wdata_i (mem_data_read_i),
    .pop_i   (rf_pop),
    .rdata_o (rd_data_o),
    .count_o (rf_count),
    .full_o  (rf_full),
    .empty_o (rf_empty)
  );

  assign wf_push   = wr_valid_i && !wf_full;
  assign rf_pop    = rd_ready_i && !rf_empty;
  assign rf_free   = DepthLen - rf_count;

  assign accept    = req_valid_i && req_ready_q;
  assign len_bad   = (req_length_i == '0) || (req_length_i > DepthLen);
  assign fill_ok   = is_write ? (wf_count >= len_q) : (rf_free >= len_q);

  // The port never stalls, so any strobe that cannot be served is a protocol error.
  assign write_active  = is_write && ((state == ST_LAUNCH) || (state == ST_RUN));
  assign wf_pop        = mem_write_ready_i && write_active && !wf_empty && (pop_cnt < len_q);
  assign wr_strobe_err = mem_write_ready_i && !wf_pop;
  assign rd_overflow   = mem_read_valid_i && rf_full && !rf_pop;

  assign req_ready_o      = req_ready_q;
  assign wr_ready_o       = !wf_full;
  assign rd_valid_o       = !rf_empty;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign mem_command_o    = command_q;
  assign mem_start_addr_o = start_q;
  assign mem_end_addr_o   = end_q;
  assign mem_data_write_o = wf_empty ? 16'h0000 : wf_rdata;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      is_write    <= 1'b0;
      armed       <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b0;
      command_q   <= MEM_IDLE;
      start_q     <= '0;
      end_q       <= '0;
      len_q       <= '0;
      pop_cnt     <= '0;
    end else begin
      if (wf_pop) pop_cnt <= pop_cnt + LenW'(1);
      if (wr_strobe_err || rd_overflow) err_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            if (len_bad) begin
              err_q <= 1'b1;
            end else begin
              is_write    <= req_write_i;
              start_q     <= req_start_addr_i;
              end_q       <= req_start_addr_i + AddrWidth'(req_length_i) - AddrWidth'(1);
              len_q       <= req_length_i;
              pop_cnt     <= '0;
              req_ready_q <= 1'b0;
              if (req_write_i ? (wf_count >= req_length_i) : (rf_free >= req_length_i)) begin
                state     <= ST_LAUNCH;
                command_q <= req_write_i ? MEM_WRITE : MEM_READ;
              end else begin
                state <= ST_FILL;
              end
            end
          end
        end
        ST_FILL: begin
          if (fill_ok) begin
            state     <= ST_LAUNCH;
            command_q <= is_write ? MEM_WRITE : MEM_READ;
          end
        end
        ST_LAUNCH: begin
          command_q <= MEM_IDLE;
          armed     <= 1'b0;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          // finished is high out of reset, so it only counts once running has been seen.
          if (mem_running_i) armed <= 1'b1;
          if (mem_task_finished_i && armed) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          command_q <= MEM_IDLE;
        end
      endcase
    end
  end

endmodule
